// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
package sdram_pkg;

    localparam int unsigned ADDR_W = 24;

    // Port tags carried on mem_port; 0 means no transaction owns the bus.
    localparam logic [1:0] PORT_IFETCH = 2'd1;
    localparam logic [1:0] PORT_DATA   = 2'd2;
    localparam logic [1:0] PORT_DMA    = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StSettle
    } arb_state_e;

    // Round-robin successor: 1 -> 2 -> 3 -> 1 (an idle tag of 0 also maps to 1).
    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p == PORT_DMA) ? PORT_IFETCH : p + 2'd1;
    endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Requester and controller-side signal bundle for the SDRAM port arbiter.
interface sdram_port_arbiter_if
    import sdram_pkg::*;
();

    // Requester side, indexed by port tag 1..3.
    logic [ADDR_W-1:0] p_addr  [1:3];
    logic [31:0]       p_wdata [1:3];
    logic [3:0]        p_be    [1:3];
    logic [3:1]        p_rd;
    logic [3:1]        p_wr;
    logic [3:1]        p_done;

    // Controller side.
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_rd;
    logic              mem_wr;
    logic [1:0]        mem_port;
    logic              mem_ready;

    // Requesters plus controller, as seen from outside the arbiter.
    modport master (
        output p_addr, p_wdata, p_be, p_rd, p_wr, mem_ready,
        input  p_done, mem_addr, mem_wdata, mem_be, mem_rd, mem_wr, mem_port
    );

    // The arbiter itself.
    modport slave (
        input  p_addr, p_wdata, p_be, p_rd, p_wr, mem_ready,
        output p_done, mem_addr, mem_wdata, mem_be, mem_rd, mem_wr, mem_port
    );

endinterface

// File: rtl/sdram_port_arbiter_rr_pick.sv
// Combinational 3-way round-robin picker with optional absolute DMA priority.
module sdram_rr_pick
    import sdram_pkg::*;
(
    input  logic [3:1] eligible,
    input  logic [1:0] last,
    input  logic       prio_en,
    output logic [1:0] grant,
    output logic       valid
);

    logic [1:0] w_cand;

    // Search from the port after the last grant; DMA short-circuits when prioritised.
    always_comb begin
        grant  = 2'd0;
        valid  = 1'b0;
        w_cand = last;
        if (prio_en && eligible[PORT_DMA]) begin
            grant = PORT_DMA;
            valid = 1'b1;
        end else begin
            for (int i = 0; i < 3; i++) begin
                w_cand = next_port(w_cand);
                if (!valid && eligible[w_cand]) begin
                    grant = w_cand;
                    valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Arbitrates three requesters onto the SDRAM controller's single request port.
module sdram_port_arbiter
    import sdram_pkg::*;
#(
    parameter bit          DMA_PRIO = 1'b1,
    parameter int unsigned DONE_DLY = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    sdram_port_arbiter_if.slave  port,
    output logic                 busy
);

    localparam int unsigned CNT_W = (DONE_DLY < 2) ? 1 : $clog2(DONE_DLY + 1);

    arb_state_e        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [1:0]        r_last, w_last_nxt;
    logic [1:0]        r_port, w_port_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [31:0]       r_wdata, w_wdata_nxt;
    logic [3:0]        r_be, w_be_nxt;
    logic              r_rd, w_rd_nxt;
    logic              r_wr, w_wr_nxt;

    logic [3:1]        w_eligible;
    logic [1:0]        w_grant;
    logic              w_valid;

    assign w_eligible = port.p_rd | port.p_wr;

    sdram_rr_pick u_pick (
        .eligible (w_eligible),
        .last     (r_last),
        .prio_en  (DMA_PRIO),
        .grant    (w_grant),
        .valid    (w_valid)
    );

    // State and registered controller-side outputs; pointer restarts at port 1.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_last  <= PORT_IFETCH;
            r_port  <= 2'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
            r_port  <= w_port_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_be    <= w_be_nxt;
            r_rd    <= w_rd_nxt;
            r_wr    <= w_wr_nxt;
        end
    end

    // Next-state: grant in IDLE, strobe for one ISSUE cycle, wait for ready, count down.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_port_nxt  = r_port;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_be_nxt    = r_be;
        w_rd_nxt    = r_rd;
        w_wr_nxt    = r_wr;
        case (r_state)
            StIdle: begin
                if (w_valid) begin
                    w_addr_nxt  = port.p_addr[w_grant];
                    w_wdata_nxt = port.p_wdata[w_grant];
                    w_be_nxt    = port.p_be[w_grant];
                    // A port asserting both strobes is serviced as a write.
                    w_wr_nxt    = port.p_wr[w_grant];
                    w_rd_nxt    = port.p_rd[w_grant] & ~port.p_wr[w_grant];
                    w_port_nxt  = w_grant;
                    w_last_nxt  = w_grant;
                    w_state_nxt = StIssue;
                end
            end
            StIssue: begin
                w_rd_nxt = 1'b0;
                w_wr_nxt = 1'b0;
                if (port.mem_ready) begin
                    w_cnt_nxt   = CNT_W'(DONE_DLY);
                    w_state_nxt = StSettle;
                end else begin
                    w_state_nxt = StWait;
                end
            end
            StWait: begin
                if (port.mem_ready) begin
                    w_cnt_nxt   = CNT_W'(DONE_DLY);
                    w_state_nxt = StSettle;
                end
            end
            StSettle: begin
                // Hold off completion until the upper read half has reached the port buffer.
                if (r_cnt == '0) begin
                    w_port_nxt  = 2'd0;
                    w_state_nxt = StIdle;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Completion pulse to the owning port on the final SETTLE cycle.
    always_comb begin
        port.p_done = '0;
        if (r_state == StSettle && r_cnt == '0) begin
            port.p_done[r_port] = 1'b1;
        end
    end

    assign port.mem_addr  = r_addr;
    assign port.mem_wdata = r_wdata;
    assign port.mem_be    = r_be;
    assign port.mem_rd    = r_rd;
    assign port.mem_wr    = r_wr;
    assign port.mem_port  = r_port;
    assign busy           = (r_state != StIdle);

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench: g_dut[0] is round-robin (DMA_PRIO=0), g_dut[1] has DMA priority.
module tb_sdram_port_arbiter;
    import sdram_pkg::*;

    localparam int unsigned DoneDly = 2;

    typedef struct {
        int          dut;
        logic [1:0]  port;
        logic [23:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        rd;
        logic        wr;
    } exp_t;

    logic        clk;
    logic        resetn;
    logic [3:1]  drv_rd    [2];
    logic [3:1]  drv_wr    [2];
    logic [23:0] drv_addr  [2][1:3];
    logic [31:0] drv_wdata [2][1:3];
    logic [3:0]  drv_be    [2][1:3];
    int unsigned ready_lat;
    exp_t        exp_q [$];
    int          errors = 0;
    int          checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sdram_port_arbiter_if u_if ();
        logic busy;
        logic ready;
        int   done_cnt [1:3];

        assign u_if.p_rd      = drv_rd[g];
        assign u_if.p_wr      = drv_wr[g];
        assign u_if.mem_ready = ready;
        for (genvar p = 1; p <= 3; p++) begin : g_p
            assign u_if.p_addr[p]  = drv_addr[g][p];
            assign u_if.p_wdata[p] = drv_wdata[g][p];
            assign u_if.p_be[p]    = drv_be[g][p];
        end

        sdram_port_arbiter #(
            .DMA_PRIO (g == 1),
            .DONE_DLY (DoneDly)
        ) u_dut (
            .clk    (clk),
            .resetn (resetn),
            .port   (u_if.slave),
            .busy   (busy)
        );

        // Controller model: ready pulses ready_lat cycles after the ISSUE cycle.
        initial begin : model
            int unsigned cnt;
            bit          pend;
            ready = 1'b0;
            pend  = 1'b0;
            cnt   = 0;
            forever begin
                @(negedge clk);
                ready = 1'b0;
                if (!resetn) begin
                    pend = 1'b0;
                end else begin
                    if (pend) begin
                        if (cnt == 0) begin
                            ready = 1'b1;
                            pend  = 1'b0;
                        end else begin
                            cnt--;
                        end
                    end
                    if (u_if.mem_rd || u_if.mem_wr) begin
                        if (ready_lat == 0) begin
                            ready = 1'b1;
                        end else begin
                            pend = 1'b1;
                            cnt  = ready_lat - 1;
                        end
                    end
                end
            end
        end

        // Monitor: pops the scoreboard on each issued command and checks completion.
        initial begin : monitor
            logic [1:0]  cur_port;
            logic [23:0] cur_addr;
            logic [31:0] cur_wdata;
            logic [3:0]  cur_be;
            logic [3:1]  exp_done;
            bit          outstanding;
            bit          prev_cmd;
            int          since;
            exp_t        e;
            for (int p = 1; p <= 3; p++) done_cnt[p] = 0;
            outstanding = 1'b0;
            prev_cmd    = 1'b0;
            since       = 1000;
            cur_port    = 2'd0;
            cur_addr    = '0;
            cur_wdata   = '0;
            cur_be      = '0;
            forever begin
                @(posedge clk);
                #1;
                if (!resetn) begin
                    outstanding = 1'b0;
                    prev_cmd    = 1'b0;
                    since       = 1000;
                    continue;
                end
                since++;
                // The ready seen here was consumed at the edge just passed.
                if (ready) since = 0;
                if (u_if.mem_rd || u_if.mem_wr) begin
                    chk($sformatf("cmd_one_cycle_d%0d", g), prev_cmd, 0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_grant d%0d: got port %0d, required none",
                                 g, u_if.mem_port);
                    end else begin
                        e = exp_q.pop_front();
                        chk("grant_dut", g, e.dut);
                        chk($sformatf("grant_port_d%0d", g), u_if.mem_port, e.port);
                        chk($sformatf("grant_addr_d%0d", g), u_if.mem_addr, e.addr);
                        chk($sformatf("grant_wdata_d%0d", g), u_if.mem_wdata, e.wdata);
                        chk($sformatf("grant_be_d%0d", g), u_if.mem_be, e.be);
                        chk($sformatf("grant_rd_d%0d", g), u_if.mem_rd, e.rd);
                        chk($sformatf("grant_wr_d%0d", g), u_if.mem_wr, e.wr);
                    end
                    cur_port    = u_if.mem_port;
                    cur_addr    = u_if.mem_addr;
                    cur_wdata   = u_if.mem_wdata;
                    cur_be      = u_if.mem_be;
                    outstanding = 1'b1;
                end else if (outstanding) begin
                    chk($sformatf("hold_d%0d", g),
                        {u_if.mem_port, u_if.mem_be, u_if.mem_addr, u_if.mem_wdata},
                        {cur_port, cur_be, cur_addr, cur_wdata});
                end
                prev_cmd = u_if.mem_rd || u_if.mem_wr;
                if (u_if.p_done != 3'b000) begin
                    exp_done = '0;
                    if (outstanding) exp_done[cur_port] = 1'b1;
                    chk($sformatf("done_port_d%0d", g), u_if.p_done, exp_done);
                    chk($sformatf("done_delay_d%0d", g), since, DoneDly);
                    for (int p = 1; p <= 3; p++) if (u_if.p_done[p]) done_cnt[p]++;
                    outstanding = 1'b0;
                end
            end
        end
    end

    function automatic logic [3:1] done_of(input int g);
        return (g == 0) ? g_dut[0].u_if.p_done : g_dut[1].u_if.p_done;
    endfunction

    function automatic logic cmd_of(input int g);
        return (g == 0) ? (g_dut[0].u_if.mem_rd | g_dut[0].u_if.mem_wr)
                        : (g_dut[1].u_if.mem_rd | g_dut[1].u_if.mem_wr);
    endfunction

    task automatic set_req(input int g, input int p, input logic rd, input logic wr,
                           input logic [23:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be);
        drv_rd[g][p]    = rd;
        drv_wr[g][p]    = wr;
        drv_addr[g][p]  = addr;
        drv_wdata[g][p] = wdata;
        drv_be[g][p]    = be;
    endtask

    task automatic expect_grant(input int g, input int p);
        exp_t e;
        e.dut   = g;
        e.port  = 2'(p);
        e.addr  = drv_addr[g][p];
        e.wdata = drv_wdata[g][p];
        e.be    = drv_be[g][p];
        e.wr    = drv_wr[g][p];
        e.rd    = drv_rd[g][p] & ~drv_wr[g][p];
        exp_q.push_back(e);
    endtask

    // Wait for n completions; ports in drop_mask release their request on p_done.
    task automatic wait_done(input int g, input int n, input logic [3:1] drop_mask,
                             input int budget);
        int         seen;
        logic [3:1] d;
        seen = 0;
        for (int cyc = 0; cyc < budget && seen < n; cyc++) begin
            @(negedge clk);
            d = done_of(g);
            for (int p = 1; p <= 3; p++) begin
                if (d[p]) begin
                    seen++;
                    if (drop_mask[p]) begin
                        drv_rd[g][p] = 1'b0;
                        drv_wr[g][p] = 1'b0;
                    end
                end
            end
        end
        chk($sformatf("done_count_d%0d", g), seen, n);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_ctl_d0"}, {g_dut[0].u_if.mem_rd, g_dut[0].u_if.mem_wr,
            g_dut[0].u_if.mem_port, g_dut[0].u_if.p_done, g_dut[0].busy}, 0);
        chk({tag, "_bus_d0"}, {g_dut[0].u_if.mem_addr, g_dut[0].u_if.mem_wdata,
            g_dut[0].u_if.mem_be}, 0);
        chk({tag, "_ctl_d1"}, {g_dut[1].u_if.mem_rd, g_dut[1].u_if.mem_wr,
            g_dut[1].u_if.mem_port, g_dut[1].u_if.p_done, g_dut[1].busy}, 0);
        chk({tag, "_bus_d1"}, {g_dut[1].u_if.mem_addr, g_dut[1].u_if.mem_wdata,
            g_dut[1].u_if.mem_be}, 0);
    endtask

    initial begin
        bit got;
        resetn    = 1'b0;
        ready_lat = 2;
        for (int g = 0; g < 2; g++) begin
            drv_rd[g] = '0;
            drv_wr[g] = '0;
            for (int p = 1; p <= 3; p++) set_req(g, p, 1'b0, 1'b0, '0, '0, '0);
        end
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        @(negedge clk);
        resetn = 1'b1;

        // All three ports at once, round-robin from reset pointer: 2, 3, 1 twice.
        for (int rep = 0; rep < 2; rep++) begin
            @(negedge clk);
            set_req(0, 1, 1'b1, 1'b0, 24'h000011, 32'h0, 4'hF);
            set_req(0, 2, 1'b1, 1'b0, 24'h000022, 32'h0, 4'h3);
            set_req(0, 3, 1'b0, 1'b1, 24'h000033, 32'h33333333, 4'hF);
            expect_grant(0, 2);
            expect_grant(0, 3);
            expect_grant(0, 1);
            wait_done(0, 3, 3'b111, 200);
        end

        // Single port-2 read; command visible one cycle after the request is sampled.
        @(negedge clk);
        set_req(0, 2, 1'b1, 1'b0, 24'h000100, 32'h0, 4'hF);
        expect_grant(0, 2);
        @(posedge clk);
        #1;
        chk("t1_issue_latency", cmd_of(0), 1'b1);
        wait_done(0, 1, 3'b010, 40);
        chk("t1_done_p1", g_dut[0].done_cnt[1], 2);
        chk("t1_done_p2", g_dut[0].done_cnt[2], 3);
        chk("t1_done_p3", g_dut[0].done_cnt[3], 2);

        // Write with a sparse byte mask to the second chip.
        ready_lat = 3;
        @(negedge clk);
        set_req(0, 1, 1'b0, 1'b1, 24'h800000, 32'hA5A5A5A5, 4'b0100);
        expect_grant(0, 1);
        wait_done(0, 1, 3'b001, 40);

        // Both strobes high with zero byte enables; ready arrives during ISSUE.
        ready_lat = 0;
        @(negedge clk);
        set_req(0, 2, 1'b1, 1'b1, 24'h400010, 32'h12345678, 4'h0);
        expect_grant(0, 2);
        wait_done(0, 1, 3'b010, 40);

        // Port 2 withdraws while waiting: still completes, never re-granted.
        ready_lat = 4;
        @(negedge clk);
        set_req(0, 2, 1'b1, 1'b0, 24'h000200, 32'h0, 4'hF);
        expect_grant(0, 2);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk);
            #1;
            got = cmd_of(0);
        end
        chk("t5_issue_seen", got, 1'b1);
        repeat (2) @(negedge clk);
        drv_rd[0][2] = 1'b0;
        wait_done(0, 1, 3'b000, 40);
        repeat (10) @(negedge clk);
        chk("t5_done_p2", g_dut[0].done_cnt[2], 5);
        chk("t5_idle", g_dut[0].busy, 1'b0);

        // DMA priority: ports 1 and 3 held; 3 wins each IDLE until it drops.
        ready_lat = 2;
        @(negedge clk);
        set_req(1, 1, 1'b1, 1'b0, 24'h000111, 32'h0, 4'hF);
        set_req(1, 3, 1'b1, 1'b0, 24'h000333, 32'h0, 4'hF);
        expect_grant(1, 3);
        expect_grant(1, 3);
        expect_grant(1, 3);
        expect_grant(1, 1);
        wait_done(1, 2, 3'b000, 100);
        wait_done(1, 1, 3'b100, 50);
        wait_done(1, 1, 3'b001, 50);
        chk("t3_done_p1", g_dut[1].done_cnt[1], 1);
        chk("t3_done_p3", g_dut[1].done_cnt[3], 3);

        // Reset during SETTLE of a port-3 transaction aborts it and rewinds the pointer.
        @(negedge clk);
        set_req(0, 3, 1'b1, 1'b0, 24'h000300, 32'h0, 4'hF);
        expect_grant(0, 3);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            got = g_dut[0].ready;
        end
        chk("t6_ready_seen", got, 1'b1);
        @(negedge clk);
        resetn = 1'b0;
        drv_rd[0] = '0;
        drv_wr[0] = '0;
        #1;
        check_quiet("in_reset");
        repeat (3) @(negedge clk);
        check_quiet("in_reset_late");
        resetn = 1'b1;
        repeat (6) @(negedge clk);
        chk("t6_no_done_p3", g_dut[0].done_cnt[3], 2);
        set_req(0, 1, 1'b1, 1'b0, 24'h000401, 32'h0, 4'hF);
        set_req(0, 2, 1'b1, 1'b0, 24'h000402, 32'h0, 4'hF);
        expect_grant(0, 2);
        expect_grant(0, 1);
        wait_done(0, 2, 3'b011, 100);
        chk("t6_done_p1", g_dut[0].done_cnt[1], 4);
        chk("t6_done_p2", g_dut[0].done_cnt[2], 6);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule
